// File: rtl/hdmi_audio_pacer_pkg.sv
// Shared rate encodings and elaboration-time NCO helpers for the HDMI audio pacer.
package audio_pacer_pkg;

    typedef enum logic [1:0] {
        RATE_48K  = 2'b00,
        RATE_44K1 = 2'b01,
        RATE_32K  = 2'b10,
        RATE_96K  = 2'b11
    } rate_e;

    function automatic int unsigned rate_hz(rate_e r);
        case (r)
            RATE_48K:  return 48000;
            RATE_44K1: return 44100;
            RATE_32K:  return 32000;
            default:   return 96000;
        endcase
    endfunction

    // Increment that toggles the NCO output twice per audio period, rounded to nearest.
    function automatic longint unsigned nco_inc(int unsigned fs, int unsigned clk_hz, int acc_bits);
        longint unsigned num;
        num = (longint'(fs) * 2) << acc_bits;
        return (num + longint'(clk_hz) / 2) / longint'(clk_hz);
    endfunction

endpackage

// File: rtl/hdmi_audio_pacer_if.sv
// PCM sample-word stream from the core audio mixer into the pacer.
interface hdmi_audio_pacer_if #(
    parameter int W = 32
) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/hdmi_audio_pacer_fifo.sv
// Small synchronous FIFO; level separates full from empty since pointers wrap freely.
module pacer_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/hdmi_audio_pacer.sv
// Fractional-NCO audio clock from the pixel clock; hands one buffered PCM word to hdmi
// on every falling edge of clk_audio.
module hdmi_audio_pacer
    import audio_pacer_pkg::*;
#(
    parameter int CLK_HZ      = 32000000,
    parameter int CHANNELS    = 2,
    parameter int SAMPLE_BITS = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int ACC_BITS    = 24,
    localparam int W  = CHANNELS * SAMPLE_BITS,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            rate_sel,
    hdmi_audio_pacer_if.slave     in_bus,
    output logic                  clk_audio,
    output logic [W-1:0]          sample_word,
    output logic                  sample_stb,
    output logic [LW-1:0]         fifo_level,
    output logic [7:0]            underflow_cnt,
    output logic                  overflow
);

    localparam logic [ACC_BITS-1:0] INC_48K  = ACC_BITS'(nco_inc(rate_hz(RATE_48K),  CLK_HZ, ACC_BITS));
    localparam logic [ACC_BITS-1:0] INC_44K1 = ACC_BITS'(nco_inc(rate_hz(RATE_44K1), CLK_HZ, ACC_BITS));
    localparam logic [ACC_BITS-1:0] INC_32K  = ACC_BITS'(nco_inc(rate_hz(RATE_32K),  CLK_HZ, ACC_BITS));
    localparam logic [ACC_BITS-1:0] INC_96K  = ACC_BITS'(nco_inc(rate_hz(RATE_96K),  CLK_HZ, ACC_BITS));

    rate_e               rate_q;
    logic [ACC_BITS-1:0] acc, acc_sum, inc;
    logic                carry, rate_chg, fall, live, full, empty;
    logic [W-1:0]        head;

    always_comb begin
        inc = INC_48K;
        case (rate_q)
            RATE_44K1: inc = INC_44K1;
            RATE_32K:  inc = INC_32K;
            RATE_96K:  inc = INC_96K;
            default:   inc = INC_48K;
        endcase
    end

    assign rate_chg        = (rate_sel != rate_q);
    assign {carry, acc_sum} = {1'b0, acc} + {1'b0, inc};
    // Update half a period ahead of the rising edge hdmi samples on.
    assign fall            = ~rate_chg & carry & clk_audio;
    // live keeps in_ready low until the first edge after reset release.
    assign in_bus.in_ready = live & ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rate_q        <= RATE_48K;
            acc           <= '0;
            clk_audio     <= 1'b0;
            sample_word   <= '0;
            sample_stb    <= 1'b0;
            underflow_cnt <= '0;
            overflow      <= 1'b0;
            live          <= 1'b0;
        end else begin
            live       <= 1'b1;
            rate_q     <= rate_e'(rate_sel);
            sample_stb <= fall;
            overflow   <= overflow | (in_bus.in_valid & ~in_bus.in_ready);
            if (rate_chg) begin
                acc <= '0;
            end else begin
                acc <= acc_sum;
                if (carry) clk_audio <= ~clk_audio;
            end
            if (fall) begin
                if (!empty)                     sample_word   <= head;
                else if (underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 8'd1;
            end
        end
    end

    pacer_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_bus.in_valid & in_bus.in_ready),
        .pop   (fall),
        .wdata (in_bus.in_data),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

endmodule
